// File: rtl/opsum_wb_pkg.sv
// rtl/opsum_wb_pkg.sv - shared FSM encoding and write-enable constant for opsum writeback
package opsum_wb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] WE_ALL = 4'hF;

endpackage

// File: rtl/opsum_writeback_lane_buffer.sv
// rtl/opsum_writeback_lane_buffer.sv - opsum lane registers with ReLU-on-load and indexed read
module opsum_lane_buffer #(
  parameter int LANE_W = 32,
  parameter int NUM    = 4,
  parameter int IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  relu,
  input  logic [LANE_W*NUM-1:0] bundle,
  input  logic [IDX_W-1:0]      idx,
  output logic [LANE_W-1:0]     rd_data
);

  logic [LANE_W-1:0] lanes [NUM];

  // Capture a whole bundle; negative lanes are zeroed here so the write path needs no data logic
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM; k++) lanes[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM; k++) begin
        if (relu && bundle[(k+1)*LANE_W-1])
          lanes[k] <= '0;
        else
          lanes[k] <= bundle[k*LANE_W +: LANE_W];
      end
    end
  end

  assign rd_data = lanes[idx];

endmodule

// File: rtl/opsum_writeback.sv
// rtl/opsum_writeback.sv - drains opsum GON bundles into consecutive OARG BRAM words
module opsum_writeback import opsum_wb_pkg::*; #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32,
  parameter int PSUM_DATA_SIZE   = 32,
  parameter int OPSUM_NUM        = 4,
  parameter int COUNT_BITWIDTH   = 16,
  parameter int ADDR_STRIDE      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDRESS_BITWIDTH-1:0]         base_address,
  input  logic [COUNT_BITWIDTH-1:0]           bundle_count,
  input  logic                                relu_en,
  input  logic                                opsum_enable,
  output logic                                opsum_ready,
  input  logic [PSUM_DATA_SIZE*OPSUM_NUM-1:0] opsum_value,
  output logic [ADDRESS_BITWIDTH-1:0]         OARG_address,
  output logic [DATA_BITWIDTH-1:0]            OARG_wdata,
  output logic                                OARG_e,
  output logic [3:0]                          OARG_we,
  output logic                                busy,
  output logic                                done
);

  localparam int IDX_W = (OPSUM_NUM > 1) ? $clog2(OPSUM_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OPSUM_NUM - 1);
  localparam logic [COUNT_BITWIDTH-1:0] ONE_LEFT = COUNT_BITWIDTH'(1);
  localparam logic [ADDRESS_BITWIDTH-1:0] STRIDE = ADDRESS_BITWIDTH'(ADDR_STRIDE);

  logic [1:0]                  state;
  logic [ADDRESS_BITWIDTH-1:0] wr_ptr;
  logic [COUNT_BITWIDTH-1:0]   left;
  logic [IDX_W-1:0]            lane_idx;
  logic                        relu_q;
  logic                        last_lane;
  logic                        xfer;
  logic [PSUM_DATA_SIZE-1:0]   rd_data;

  // Ready in WAIT, and on the last lane of a bundle that is not the final one so bundles can chain
  assign last_lane   = (state == ST_WRITE) && (lane_idx == LAST_IDX);
  assign opsum_ready = (state == ST_WAIT) || (last_lane && (left != ONE_LEFT));
  assign xfer        = opsum_enable && opsum_ready;

  opsum_lane_buffer #(
    .LANE_W (PSUM_DATA_SIZE),
    .NUM    (OPSUM_NUM),
    .IDX_W  (IDX_W)
  ) u_lane_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .relu    (relu_q),
    .bundle  (opsum_value),
    .idx     (lane_idx),
    .rd_data (rd_data)
  );

  // Sequencer: config latch, per-lane address advance, bundle countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      left     <= '0;
      lane_idx <= '0;
      relu_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            wr_ptr   <= base_address;
            left     <= bundle_count;
            relu_q   <= relu_en;
            lane_idx <= '0;
            state    <= (bundle_count == '0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (xfer) begin
            lane_idx <= '0;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_ptr <= wr_ptr + STRIDE;
          if (lane_idx == LAST_IDX) begin
            lane_idx <= '0;
            left     <= left - ONE_LEFT;
            if (left == ONE_LEFT) state <= ST_DONE;
            else if (xfer)        state <= ST_WRITE;
            else                  state <= ST_WAIT;
          end else begin
            lane_idx <= lane_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Port signals are decoded purely from registered state, so they settle right after the edge
  always_comb begin
    OARG_e       = (state == ST_WRITE);
    OARG_we      = (state == ST_WRITE) ? WE_ALL : 4'h0;
    OARG_address = (state == ST_WRITE) ? wr_ptr : '0;
    OARG_wdata   = (state == ST_WRITE) ? DATA_BITWIDTH'(rd_data) : '0;
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
  end

endmodule

// File: tb/tb_opsum_writeback.sv
// tb/tb_opsum_writeback.sv - directed self-checking bench for opsum_writeback
module tb_opsum_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_address;
  logic [15:0]  bundle_count;
  logic         relu_en;
  logic         opsum_enable;
  logic         opsum_ready;
  logic [127:0] opsum_value;
  logic [31:0]  oarg_address;
  logic [31:0]  oarg_wdata;
  logic         oarg_e;
  logic [3:0]   oarg_we;
  logic         busy;
  logic         done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opsum_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_address (base_address),
    .bundle_count (bundle_count),
    .relu_en      (relu_en),
    .opsum_enable (opsum_enable),
    .opsum_ready  (opsum_ready),
    .opsum_value  (opsum_value),
    .OARG_address (oarg_address),
    .OARG_wdata   (oarg_wdata),
    .OARG_e       (oarg_e),
    .OARG_we      (oarg_we),
    .busy         (busy),
    .done         (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic rdy);
    chk({tag, " e"},     32'(oarg_e), 32'd1);
    chk({tag, " we"},    32'(oarg_we), 32'hF);
    chk({tag, " addr"},  oarg_address, addr);
    chk({tag, " data"},  oarg_wdata, data);
    chk({tag, " ready"}, 32'(opsum_ready), 32'(rdy));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " e"},  32'(oarg_e), 32'd0);
    chk({tag, " we"}, 32'(oarg_we), 32'd0);
  endtask

  function automatic logic [127:0] seq_bundle(input int b);
    logic [127:0] v;
    for (int l = 0; l < 4; l++) v[l*32 +: 32] = 32'h1000 * b + 32'(l) + 32'h10;
    return v;
  endfunction

  localparam logic [127:0] B_SINGLE = {32'h7FFFFFFF, 32'd7, 32'hFFFFFFFD, 32'd4};

  initial begin
    rst = 1'b1; start = 1'b0; base_address = '0; bundle_count = '0; relu_en = 1'b0;
    opsum_enable = 1'b0; opsum_value = '0;

    // reset held for three cycles
    step(); step(); step();
    chk("rst ready", 32'(opsum_ready), 32'd0);
    chk_quiet("rst");
    chk("rst addr", oarg_address, 32'd0);
    chk("rst wdata", oarg_wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);

    // valid without start is ignored
    rst = 1'b0; opsum_enable = 1'b1; opsum_value = B_SINGLE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle ready", 32'(opsum_ready), 32'd0);
      chk_quiet("idle");
      chk("idle busy", 32'(busy), 32'd0);
    end

    // single bundle, no ReLU
    start = 1'b1; base_address = 32'h100; bundle_count = 16'd1; relu_en = 1'b0;
    step(); start = 1'b0;
    chk("single wait ready", 32'(opsum_ready), 32'd1);
    chk("single wait busy", 32'(busy), 32'd1);
    chk_quiet("single wait");
    step(); opsum_enable = 1'b0;
    chk_write("single w0", 32'h100, 32'd4, 1'b0);
    step(); chk_write("single w1", 32'h104, 32'hFFFFFFFD, 1'b0);
    step(); chk_write("single w2", 32'h108, 32'd7, 1'b0);
    step(); chk_write("single w3", 32'h10C, 32'h7FFFFFFF, 1'b0);
    step();
    chk("single done", 32'(done), 32'd1);
    chk("single done busy", 32'(busy), 32'd1);
    chk_quiet("single done");
    step();
    chk("single idle done", 32'(done), 32'd0);
    chk("single idle busy", 32'(busy), 32'd0);

    // single bundle with ReLU
    start = 1'b1; relu_en = 1'b1; opsum_enable = 1'b1; opsum_value = B_SINGLE;
    step(); start = 1'b0; relu_en = 1'b0;
    step(); opsum_enable = 1'b0;
    chk_write("relu w0", 32'h100, 32'd4, 1'b0);
    step(); chk_write("relu w1", 32'h104, 32'd0, 1'b0);
    step(); chk_write("relu w2", 32'h108, 32'd7, 1'b0);
    step(); chk_write("relu w3", 32'h10C, 32'h7FFFFFFF, 1'b0);
    step(); chk("relu done", 32'(done), 32'd1);
    step();

    // back-to-back, three bundles, producer always valid
    start = 1'b1; base_address = 32'h100; bundle_count = 16'd3;
    opsum_enable = 1'b1; opsum_value = seq_bundle(0);
    step(); start = 1'b0;
    chk("b2b wait ready", 32'(opsum_ready), 32'd1);
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < 4; l++) begin
        step();
        chk_write($sformatf("b2b b%0d l%0d", b, l), 32'h100 + 32'(16 * b + 4 * l),
                  32'h1000 * b + 32'(l) + 32'h10, (l == 3) && (b < 2));
        if (l == 0) begin
          if (b < 2) opsum_value = seq_bundle(b + 1);
          else       opsum_enable = 1'b0;
        end
      end
    end
    step(); chk("b2b done", 32'(done), 32'd1); chk_quiet("b2b done");
    step();

    // stall: second bundle arrives five cycles late
    start = 1'b1; base_address = 32'h200; bundle_count = 16'd2;
    opsum_enable = 1'b1; opsum_value = seq_bundle(0);
    step(); start = 1'b0;
    step(); opsum_enable = 1'b0;
    chk_write("stall b0 l0", 32'h200, 32'h10, 1'b0);
    step(); chk_write("stall b0 l1", 32'h204, 32'h11, 1'b0);
    step(); chk_write("stall b0 l2", 32'h208, 32'h12, 1'b0);
    step(); chk_write("stall b0 l3", 32'h20C, 32'h13, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_quiet($sformatf("stall gap %0d", i));
      chk("stall gap ready", 32'(opsum_ready), 32'd1);
      chk("stall gap busy", 32'(busy), 32'd1);
    end
    opsum_enable = 1'b1; opsum_value = seq_bundle(1);
    step(); opsum_enable = 1'b0;
    chk_write("stall b1 l0", 32'h210, 32'h1010, 1'b0);
    step(); chk_write("stall b1 l1", 32'h214, 32'h1011, 1'b0);
    step(); chk_write("stall b1 l2", 32'h218, 32'h1012, 1'b0);
    step(); chk_write("stall b1 l3", 32'h21C, 32'h1013, 1'b0);
    step(); chk("stall done", 32'(done), 32'd1);
    step();

    // zero bundles: done one cycle after start, no writes
    start = 1'b1; base_address = 32'h300; bundle_count = 16'd0;
    step(); start = 1'b0;
    chk("zero done", 32'(done), 32'd1);
    chk_quiet("zero");
    chk("zero ready", 32'(opsum_ready), 32'd0);
    step();
    chk("zero idle done", 32'(done), 32'd0);
    chk_quiet("zero idle");

    // address wrap
    start = 1'b1; base_address = 32'hFFFFFFFC; bundle_count = 16'd1;
    opsum_enable = 1'b1; opsum_value = seq_bundle(2);
    step(); start = 1'b0;
    step(); opsum_enable = 1'b0;
    chk_write("wrap l0", 32'hFFFFFFFC, 32'h2010, 1'b0);
    step(); chk_write("wrap l1", 32'h0, 32'h2011, 1'b0);
    step(); chk_write("wrap l2", 32'h4, 32'h2012, 1'b0);
    step(); chk_write("wrap l3", 32'h8, 32'h2013, 1'b0);
    step(); chk("wrap done", 32'(done), 32'd1);
    step();

    // reset after the second write abandons the transfer
    start = 1'b1; base_address = 32'h300; bundle_count = 16'd2;
    opsum_enable = 1'b1; opsum_value = seq_bundle(3);
    step(); start = 1'b0;
    step(); opsum_enable = 1'b0;
    chk_write("mid w0", 32'h300, 32'h3010, 1'b0);
    step(); chk_write("mid w1", 32'h304, 32'h3011, 1'b0);
    rst = 1'b1;
    step();
    chk_quiet("mid rst");
    chk("mid rst ready", 32'(opsum_ready), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid after done", 32'(done), 32'd0);
      chk_quiet("mid after");
    end

    // fresh start after reset
    start = 1'b1; base_address = 32'h400; bundle_count = 16'd1;
    opsum_enable = 1'b1; opsum_value = seq_bundle(4);
    step(); start = 1'b0;
    step(); opsum_enable = 1'b0;
    chk_write("again w0", 32'h400, 32'h4010, 1'b0);
    step(); chk_write("again w1", 32'h404, 32'h4011, 1'b0);
    step(); chk_write("again w2", 32'h408, 32'h4012, 1'b0);
    step(); chk_write("again w3", 32'h40C, 32'h4013, 1'b0);
    step(); chk("again done", 32'(done), 32'd1);
    step(); chk("again idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
